ah_packet_converter_n2w_20_32: RTL and testbench

AH_PACKET_CONVERTER_N2W_20_32 -- requirements
Module: ah_packet_converter_n2w_20_32

---
 rtl/ah_packet_converter_n2w_20_32.sv | 73 +++++++
 tb/tb_ah_packet_converter_n2w_20_32.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ah_packet_converter_n2w_20_32.sv
// Narrow-to-wide packet converter: packs 20-bit input words into 32-bit output words,
// zero-padding the final word of each packet and flagging it with wlast.
module ah_packet_converter_n2w_20_32 (
  input  logic        clk,
  input  logic        rstn,
  input  logic [19:0] rdata,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  output logic [31:0] wdata,
  output logic        wvalid,
  output logic        wlast,
  input  logic        wready
);

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [51:0] acc, acc_next;
  logic [5:0]  cnt, cnt_next;
  logic        r_xfer, w_xfer;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    rready     = (state == ACCUM) && (cnt < 6'd32);
    wvalid     = (cnt >= 6'd32) || ((state == FLUSH) && (cnt != 6'd0));
    wlast      = wvalid && (state == FLUSH) && (cnt <= 6'd32);
    r_xfer     = rvalid && rready;
    w_xfer     = wvalid && wready;
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;

    // Bits at and above the fill level are forced to zero on the output word.
    if (cnt >= 6'd32) wdata = acc[31:0];
    else              wdata = acc[31:0] & ~({32{1'b1}} << cnt[4:0]);

    // rready and wvalid can never both fire, so the two update paths are exclusive.
    if (r_xfer) begin
      acc_next = (acc & ~(52'hFFFFF << cnt)) | (52'(rdata) << cnt);
      cnt_next = cnt + 6'd20;
      if (rlast) state_next = FLUSH;
    end else if (w_xfer) begin
      if (wlast) begin
        acc_next   = '0;
        cnt_next   = '0;
        state_next = ACCUM;
      end else begin
        acc_next = acc >> 32;
        cnt_next = cnt - 6'd32;
      end
    end
  end

endmodule

// File: tb/tb_ah_packet_converter_n2w_20_32.sv
// Directed self-checking bench for ah_packet_converter_n2w_20_32 with hand-computed
// expected wide words.
module tb_ah_packet_converter_n2w_20_32;

  logic        clk = 1'b0;
  logic        rstn;
  logic [19:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wlast;
  logic        wready;

  int tests = 0;
  int fails = 0;

  logic [19:0] in_words [8];
  logic [31:0] exp_w    [5];
  logic        exp_l    [5];

  ah_packet_converter_n2w_20_32 dut (
    .clk    (clk),
    .rstn   (rstn),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rlast  (rlast),
    .rready (rready),
    .wdata  (wdata),
    .wvalid (wvalid),
    .wlast  (wlast),
    .wready (wready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers n_in words from in_words with wready=1 and checks each wide word in order.
  task automatic run(input int n_in, input bit last_final, input int n_out,
                     input string tag, output int cycles);
    int   ii  = 0;
    int   oo  = 0;
    int   cyc = 0;
    logic took;
    wready = 1'b1;
    while ((ii < n_in || oo < n_out) && cyc < 64) begin
      rvalid = (ii < n_in);
      rdata  = '0;
      if (ii < n_in) rdata = in_words[ii];
      rlast  = last_final && (ii == n_in - 1);
      #1;
      if (wvalid) begin
        if (oo < n_out) begin
          check({tag, " wdata"}, wdata, exp_w[oo]);
          check({tag, " wlast"}, 32'(wlast), 32'(exp_l[oo]));
          check({tag, " rready during output"}, 32'(rready), 32'd0);
        end else begin
          check({tag, " extra wide word"}, 32'(wvalid), 32'd0);
        end
        oo++;
      end
      took = rvalid && rready;
      step();
      if (took) ii++;
      cyc++;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    check({tag, " narrow words taken"}, 32'(ii), 32'(n_in));
    check({tag, " wide words seen"}, 32'(oo), 32'(n_out));
    #1;
    check({tag, " idle wvalid"}, 32'(wvalid), 32'd0);
    check({tag, " idle rready"}, 32'(rready), 32'd1);
    cycles = cyc;
  endtask

  task automatic load_stream();
    for (int i = 0; i < 8; i++) in_words[i] = 20'(i + 1);
    exp_w[0] = 32'h0020_0001;
    exp_w[1] = 32'h4000_0300;
    exp_w[2] = 32'h0005_0000;
    exp_w[3] = 32'h0700_0060;
    exp_w[4] = 32'h0000_8000;
    for (int i = 0; i < 5; i++) exp_l[i] = 1'b0;
  endtask

  initial begin
    int   cyc;
    int   n;
    logic took;

    rstn   = 1'b0;
    rvalid = 1'b0;
    rlast  = 1'b0;
    rdata  = '0;
    wready = 1'b0;

    // Reset values while held and after release.
    #12;
    check("in reset rready", 32'(rready), 32'd1);
    check("in reset wvalid", 32'(wvalid), 32'd0);
    check("in reset wlast", 32'(wlast), 32'd0);
    check("in reset wdata", wdata, 32'h0);
    rstn = 1'b1;
    step();
    check("post reset rready", 32'(rready), 32'd1);
    check("post reset wvalid", 32'(wvalid), 32'd0);
    check("post reset wdata", wdata, 32'h0);

    // Sustained stream: 8 narrow words in, 5 wide words out in 13 cycles.
    load_stream();
    run(8, 1'b0, 5, "stream", cyc);
    check("stream cycles", 32'(cyc), 32'd13);

    // Single-word packet, zero padded.
    in_words[0] = 20'hABCDE;
    exp_w[0]    = 32'h000A_BCDE;
    exp_l[0]    = 1'b1;
    run(1, 1'b1, 1, "single", cyc);
    check("single cycles", 32'(cyc), 32'd2);

    // Two-word packet spilling 8 bits into a second wide word.
    in_words[0] = 20'hFFFFF;
    in_words[1] = 20'hFFFFF;
    exp_w[0]    = 32'hFFFF_FFFF;
    exp_l[0]    = 1'b0;
    exp_w[1]    = 32'h0000_00FF;
    exp_l[1]    = 1'b1;
    run(2, 1'b1, 2, "two word", cyc);
    check("two word cycles", 32'(cyc), 32'd4);

    // Backpressure with 40 bits held.
    wready = 1'b0;
    rvalid = 1'b1;
    rlast  = 1'b0;
    rdata  = 20'h12345;
    step();
    rdata  = 20'h6789A;
    step();
    rdata  = 20'hFEDCB;
    rlast  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall rready", 32'(rready), 32'd0);
      check("stall wvalid", 32'(wvalid), 32'd1);
      check("stall wlast", 32'(wlast), 32'd0);
      check("stall wdata", wdata, 32'h89A1_2345);
      step();
    end
    wready = 1'b1;
    #1;
    check("resume wdata", wdata, 32'h89A1_2345);
    step();
    check("resume rready", 32'(rready), 32'd1);
    check("resume wvalid residue", 32'(wvalid), 32'd0);
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;
    check("tail wvalid", 32'(wvalid), 32'd1);
    check("tail wlast", 32'(wlast), 32'd1);
    check("tail wdata", wdata, 32'h0FED_CB67);
    check("tail rready", 32'(rready), 32'd0);
    step();
    check("after tail wvalid", 32'(wvalid), 32'd0);
    check("after tail rready", 32'(rready), 32'd1);

    // Reset after three narrow words discards the partial data.
    in_words[0] = 20'hAAAAA;
    in_words[1] = 20'hBBBBB;
    in_words[2] = 20'hCCCCC;
    wready = 1'b1;
    n      = 0;
    cyc    = 0;
    while (n < 3 && cyc < 20) begin
      rvalid = 1'b1;
      rdata  = in_words[n];
      #1;
      took = rvalid && rready;
      step();
      if (took) n++;
      cyc++;
    end
    rvalid = 1'b0;
    check("pre-reset words taken", 32'(n), 32'd3);
    check("pre-reset partial present", 32'(rready), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("mid reset wvalid", 32'(wvalid), 32'd0);
    check("mid reset wdata", wdata, 32'h0);
    check("mid reset rready", 32'(rready), 32'd1);
    #2 rstn = 1'b1;
    step();
    check("post mid reset wvalid", 32'(wvalid), 32'd0);
    load_stream();
    run(8, 1'b0, 5, "stream after reset", cyc);
    check("stream after reset cycles", 32'(cyc), 32'd13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
